regfile_issue_scheduler: RTL
============================

Name: regfile_issue_scheduler

Overview:
- Scoreboard and write-port scheduler for the dual-issue 8x32 register file.
- Issue side: decides each cycle whether issue slot 0 and/or slot 1 may read operands and issue, using per-register busy bits. This blocks RAW, WAW and intra-pair hazards.
- Writeback side: arbitrates three result producers (ALU0, ALU1, MEM) round-robin onto the register file's two write ports, and clears busy bits as writes land.

Parameters:
- DW, 32, register/data width
- AW, 3, register index width; NREG = 2**AW = 8 registers

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- iss0_valid  in  1  slot 0 holds an instruction
- iss0_src  in  3*AW  three source indices {src2,src1,src0}
- iss0_srcv  in  3  per-source "used" mask
- iss0_wr  in  1  slot 0 writes a destination
- iss0_dst  in  AW  slot 0 destination index
- iss1_valid, iss1_src, iss1_srcv, iss1_wr, iss1_dst  in  (same widths)  slot 1 equivalents
- iss0_grant  out  1  slot 0 issues this cycle (combinational)
- iss1_grant  out  1  slot 1 issues this cycle (combinational)
- wb_req  in  3  result-valid per producer (bit0 ALU0, bit1 ALU1, bit2 MEM)
- wb_dst  in  3*AW  destination per producer
- wb_data  in  3*DW  result per producer
- wb_ack  out  3  producer result accepted this cycle (combinational)
- regWrite1, regWrite2  out  1  register-file write enables (registered)
- destReg1, destReg2  out  AW  write indices (registered)
- writeData1, writeData2  out  DW  write data (registered)
- busy  out  NREG  scoreboard state
- wb_err  out  1  sticky: a write targeted a non-busy register

Behaviour:
- Reset (synchronous, highest priority):
  - busy=0, regWrite1/2=0, destReg1/2=0, writeData1/2=0, wb_err=0, RR pointer=0.
  - Combinational grants/acks follow from the reset state in the next cycle.
- Slot 0 hazard: any used source with busy[src]=1, or iss0_wr with busy[iss0_dst]=1.
- iss0_grant = iss0_valid & !hazard0.
- iss1_grant = iss0_grant & iss1_valid & !hazard1 & !pair_hazard (in-order issue; slot 1 never passes slot 0).
  - pair_hazard: iss0_wr and (a used slot-1 source == iss0_dst, or iss1_wr with iss1_dst == iss0_dst).
- Granted slot with wr: busy[dst] set at the clock edge ending the grant cycle.
- Busy checks use current-cycle busy only; there is no bypass.
- Writeback arbitration (combinational in the request cycle):
  - Scan requesters from RR pointer p in order p, p+1, p+2 (mod 3).
  - First requester found goes to port 1, second to port 2, third is not acked.
  - Producers hold wb_req/wb_dst/wb_data stable until acked.
  - p advances to (index of last acked requester)+1 mod 3; p is unchanged if nothing is acked.
- Write outputs: registered one cycle after ack (latency 1).
  - Unused port: regWrite=0, dest/data hold previous values.
- Busy clear: at the edge ending a cycle in which regWrite1/2 is high, clear busy[destRegN]. The register file commits at that same edge, so a reader issues only once the data is present.
- Set and clear of the same index on the same edge: set wins.
- wb_err: set when a write is emitted to an index whose busy bit is 0. Cleared only by reset. The write is still performed.
- Two writes to the same index on the same cycle cannot arise, because WAW blocking prevents it. If it does occur, port 2 data is written and wb_err is set.
- Reset mid-operation discards all pending busy state and any registered write; producers must drop outstanding results.

Decomposition:
- Shared package holds:
  - requester ID constants REQ_ALU0=0, REQ_ALU1=1, REQ_MEM=2, and NREQ=3
  - AW/DW defaults
  - packed issue-slot typedef (valid, src, srcv, wr, dst)
- One sub-module: wb_rr_arbiter2 — 3-requester, 2-grant round-robin with its pointer register. The scoreboard and hazard logic stay in the top.

Test Plan:
- Post-reset, slot0 wr r3, slot1 reads r3 -> iss0_grant=1, iss1_grant=0. Next cycle busy=8'h08.
- busy[3]=1; ALU0 req r3 data 32'hDEADBEEF -> wb_ack=3'b001. Next cycle regWrite1=1, destReg1=3, writeData1=32'hDEADBEEF. The cycle after, busy[3]=0 and a slot0 read of r3 is granted.
- All three producers request with p=0 -> wb_ack=3'b011, p=2. Next cycle MEM still requesting plus ALU0 -> ack MEM (port 1), ALU0 (port 2), p=1.
- Slot0 wr r5 with busy[5]=1 -> iss0_grant=0, iss1_grant=0 even when slot 1 is hazard-free.
- Write emitted to r6 with busy[6]=0 -> register write occurs, wb_err=1 and stays 1 until reset. Reset while busy=8'hFF -> next cycle busy=0, regWrite1/2=0, wb_err=0.
- Same-edge set/clear: regWrite1 to r2 while slot0 granted wr r2 (forced via busy clear timing) -> busy[2]=1 after the edge.

Source files
------------

// File: rtl/regfile_issue_scheduler_pkg.sv
// Shared definitions for the register-file issue scheduler: producer IDs,
// default widths, the issue-slot bundle and the round-robin wrap helper.
package regfile_issue_scheduler_pkg;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 32;
  localparam int NREQ   = 3;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_ALU0 = 2'd0;
  localparam req_id_t REQ_ALU1 = 2'd1;
  localparam req_id_t REQ_MEM  = 2'd2;

  typedef struct packed {
    logic                  valid;
    logic [3*AW_DEF-1:0]   src;
    logic [2:0]            srcv;
    logic                  wr;
    logic [AW_DEF-1:0]     dst;
  } iss_slot_t;

  function automatic req_id_t req_next(input req_id_t id);
    return (id == REQ_MEM) ? REQ_ALU0 : req_id_t'(id + 2'd1);
  endfunction

endpackage

// File: rtl/regfile_issue_scheduler_arb.sv
// Three-requester, two-grant round-robin arbiter feeding the two
// register-file write ports; owns the rotating priority pointer.
module wb_rr_arbiter2
  import regfile_issue_scheduler_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_ack,
  output logic            o_p1_vld,
  output req_id_t         o_p1_sel,
  output logic            o_p2_vld,
  output req_id_t         o_p2_sel
);

  req_id_t r_ptr;
  req_id_t w_ptr_nxt;
  req_id_t w_idx;
  req_id_t w_last;

  always_comb begin
    o_ack    = '0;
    o_p1_vld = 1'b0;
    o_p1_sel = REQ_ALU0;
    o_p2_vld = 1'b0;
    o_p2_sel = REQ_ALU0;
    w_idx    = r_ptr;
    w_last   = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (i_req[w_idx]) begin
        if (!o_p1_vld) begin
          o_p1_vld     = 1'b1;
          o_p1_sel     = w_idx;
          o_ack[w_idx] = 1'b1;
          w_last       = w_idx;
        end else if (!o_p2_vld) begin
          o_p2_vld     = 1'b1;
          o_p2_sel     = w_idx;
          o_ack[w_idx] = 1'b1;
          w_last       = w_idx;
        end
      end
      w_idx = req_next(w_idx);
    end
    // pointer moves just past the last winner so the loser goes first next time
    w_ptr_nxt = (o_ack != '0) ? req_next(w_last) : r_ptr;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_ptr <= REQ_ALU0;
    else         r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/regfile_issue_scheduler.sv
// Busy-bit scoreboard for dual in-order issue plus registered write-port
// scheduling of ALU0/ALU1/MEM results onto the 8x32 register file.
module regfile_issue_scheduler
  import regfile_issue_scheduler_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_iss0_valid,
  input  logic [3*AW-1:0]      i_iss0_src,
  input  logic [2:0]           i_iss0_srcv,
  input  logic                 i_iss0_wr,
  input  logic [AW-1:0]        i_iss0_dst,
  input  logic                 i_iss1_valid,
  input  logic [3*AW-1:0]      i_iss1_src,
  input  logic [2:0]           i_iss1_srcv,
  input  logic                 i_iss1_wr,
  input  logic [AW-1:0]        i_iss1_dst,
  output logic                 o_iss0_grant,
  output logic                 o_iss1_grant,
  input  logic [NREQ-1:0]      i_wb_req,
  input  logic [NREQ*AW-1:0]   i_wb_dst,
  input  logic [NREQ*DW-1:0]   i_wb_data,
  output logic [NREQ-1:0]      o_wb_ack,
  output logic                 o_regWrite1,
  output logic                 o_regWrite2,
  output logic [AW-1:0]        o_destReg1,
  output logic [AW-1:0]        o_destReg2,
  output logic [DW-1:0]        o_writeData1,
  output logic [DW-1:0]        o_writeData2,
  output logic [(2**AW)-1:0]   o_busy,
  output logic                 o_wb_err
);

  localparam int NREG = 2**AW;

  iss_slot_t        w_s0, w_s1;
  logic             w_hz0, w_hz1, w_pair;
  logic [NREG-1:0]  r_busy, w_busy_nxt;
  logic             r_reg_write1, r_reg_write2, r_wb_err, w_err_evt;
  logic [AW-1:0]    r_dest1, r_dest2;
  logic [DW-1:0]    r_data1, r_data2;
  logic             w_p1_vld, w_p2_vld;
  req_id_t          w_p1_sel, w_p2_sel;
  logic [AW-1:0]    w_dst [NREQ];
  logic [DW-1:0]    w_dat [NREQ];

  assign w_s0 = '{valid: i_iss0_valid, src: i_iss0_src, srcv: i_iss0_srcv,
                  wr: i_iss0_wr, dst: i_iss0_dst};
  assign w_s1 = '{valid: i_iss1_valid, src: i_iss1_src, srcv: i_iss1_srcv,
                  wr: i_iss1_wr, dst: i_iss1_dst};

  always_comb begin
    w_hz0  = w_s0.wr & r_busy[w_s0.dst];
    w_hz1  = w_s1.wr & r_busy[w_s1.dst];
    w_pair = w_s0.wr & w_s1.wr & (w_s1.dst == w_s0.dst);
    for (int i = 0; i < 3; i++) begin
      w_hz0  = w_hz0 | (w_s0.srcv[i] & r_busy[w_s0.src[i*AW +: AW]]);
      w_hz1  = w_hz1 | (w_s1.srcv[i] & r_busy[w_s1.src[i*AW +: AW]]);
      w_pair = w_pair | (w_s0.wr & w_s1.srcv[i] & (w_s1.src[i*AW +: AW] == w_s0.dst));
    end
  end

  // slot 1 may only issue alongside slot 0, never past it
  assign o_iss0_grant = w_s0.valid & ~w_hz0;
  assign o_iss1_grant = o_iss0_grant & w_s1.valid & ~w_hz1 & ~w_pair;

  for (genvar g = 0; g < NREQ; g++) begin : g_wb_split
    assign w_dst[g] = i_wb_dst[g*AW +: AW];
    assign w_dat[g] = i_wb_data[g*DW +: DW];
  end

  wb_rr_arbiter2 u_arb (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_req    (i_wb_req),
    .o_ack    (o_wb_ack),
    .o_p1_vld (w_p1_vld),
    .o_p1_sel (w_p1_sel),
    .o_p2_vld (w_p2_vld),
    .o_p2_sel (w_p2_sel)
  );

  // clears first, then sets, so a same-edge set on the same index wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_reg_write1) w_busy_nxt[r_dest1] = 1'b0;
    if (r_reg_write2) w_busy_nxt[r_dest2] = 1'b0;
    if (o_iss0_grant & w_s0.wr) w_busy_nxt[w_s0.dst] = 1'b1;
    if (o_iss1_grant & w_s1.wr) w_busy_nxt[w_s1.dst] = 1'b1;
  end

  assign w_err_evt = (r_reg_write1 & ~r_busy[r_dest1])
                   | (r_reg_write2 & ~r_busy[r_dest2])
                   | (r_reg_write1 & r_reg_write2 & (r_dest1 == r_dest2));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy       <= '0;
      r_reg_write1 <= 1'b0;
      r_reg_write2 <= 1'b0;
      r_dest1      <= '0;
      r_dest2      <= '0;
      r_data1      <= '0;
      r_data2      <= '0;
      r_wb_err     <= 1'b0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_reg_write1 <= w_p1_vld;
      r_reg_write2 <= w_p2_vld;
      if (w_p1_vld) begin
        r_dest1 <= w_dst[w_p1_sel];
        r_data1 <= w_dat[w_p1_sel];
      end
      if (w_p2_vld) begin
        r_dest2 <= w_dst[w_p2_sel];
        r_data2 <= w_dat[w_p2_sel];
      end
      if (w_err_evt) r_wb_err <= 1'b1;
    end
  end

  assign o_regWrite1  = r_reg_write1;
  assign o_regWrite2  = r_reg_write2;
  assign o_destReg1   = r_dest1;
  assign o_destReg2   = r_dest2;
  assign o_writeData1 = r_data1;
  assign o_writeData2 = r_data2;
  assign o_busy       = r_busy;
  assign o_wb_err     = r_wb_err;

endmodule
